// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
//   state  | meaning
//   S_IDLE | ready; start launches a mult/div or performs an MTHI/MTLO write
//   S_BUSY | result held in pending regs, counting down to HI/LO write-back
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDresult
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MTHI  = 4'b0101;
    localparam logic [3:0] OP_MTLO  = 4'b0110;
    localparam logic [3:0] OP_MFHI  = 4'b0111;
    localparam logic [3:0] OP_MFLO  = 4'b1000;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
    localparam logic [3:0] OP_MSUBU = 4'b1100;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic        div_sgn;
    logic [31:0] dvd, dvs, dvs_nz, quo, rem, div_lo, div_hi;
    logic        is_md, is_mul, is_div;
    logic [63:0] md_res;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 with no special case.
    assign div_sgn = (MDop == OP_DIV);
    assign dvd     = (div_sgn && A[31]) ? (32'd0 - A) : A;
    assign dvs     = (div_sgn && B[31]) ? (32'd0 - B) : B;
    assign dvs_nz  = (dvs == 32'd0) ? 32'd1 : dvs;
    assign quo     = dvd / dvs_nz;
    assign rem     = dvd % dvs_nz;
    assign div_lo  = (div_sgn && (A[31] ^ B[31])) ? (32'd0 - quo) : quo;
    assign div_hi  = (div_sgn && A[31]) ? (32'd0 - rem) : rem;

    always_comb begin
        is_md  = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        md_res = '0;
        case (MDop)
            OP_MULT:  begin is_md = 1'b1; is_mul = 1'b1; md_res = prod_s; end
            OP_MULTU: begin is_md = 1'b1; is_mul = 1'b1; md_res = prod_u; end
            OP_DIV,
            OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; md_res = {div_hi, div_lo}; end
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_md = 1'b1; is_mul = 1'b1; md_res = {hi_q, lo_q} + prod_s; end
            OP_MADDU: begin is_md = 1'b1; is_mul = 1'b1; md_res = {hi_q, lo_q} + prod_u; end
            OP_MSUB:  begin is_md = 1'b1; is_mul = 1'b1; md_res = {hi_q, lo_q} - prod_s; end
            OP_MSUBU: begin is_md = 1'b1; is_mul = 1'b1; md_res = {hi_q, lo_q} - prod_u; end
`endif
            default:  ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_md) begin
                        state_d   = S_BUSY;
                        cnt_d     = is_mul ? MULT_N : DIV_N;
                        pend_d    = md_res;
                        pend_wr_d = !(is_div && (B == 32'd0));
                    end else if (MDop == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDop == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d   = S_IDLE;
                    cnt_d     = 4'd0;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDresult = 32'd0;
        if (MDop == OP_MFHI) MDresult = hi_q;
        else if (MDop == OP_MFLO) MDresult = lo_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus randomized ops against an arithmetic model.
`timescale 1ns/1ps
module tb_mdu_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  MDop = OP_NOP;
    logic        start = 1'b0;
    logic        busy;
    logic [31:0] HI, LO, MDresult;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .A(A), .B(B), .MDop(MDop), .start(start),
        .busy(busy), .HI(HI), .LO(LO), .MDresult(MDresult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op >= OP_MADD && op <= OP_MSUBU);
    endfunction

    // Reference: new {HI,LO} for a mult/div class op given the {HI,LO} at launch.
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV:   return (b == 32'd0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  return (b == 32'd0) ? acc : {32'(ua % ub), 32'(ua / ub)};
`ifdef MDU_MADD_EN
            OP_MADD:  return acc + 64'(sa * sb);
            OP_MADDU: return acc + ua * ub;
            OP_MSUB:  return acc - 64'(sa * sb);
            OP_MSUBU: return acc - ua * ub;
`endif
            default:  return acc;
        endcase
    endfunction

    // Launch op, optionally pulse a second start (inj_op) after the inj_cyc-th busy cycle.
    task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inj_cyc, input logic [3:0] inj_op,
                          input logic [31:0] inj_a);
        logic [63:0] expv;
        int          cnt;
        bit          done;
        expv = ref_md(op, a, b, {exp_hi, exp_lo});
        @(negedge clk);
        start = 1'b1; MDop = op; A = a; B = b;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            start = 1'b0; MDop = OP_NOP; A = $urandom; B = $urandom;
            if (!busy) begin
                done = 1'b1;
            end else begin
                cnt++;
                if (cnt == inj_cyc) begin
                    start = 1'b1; MDop = inj_op; A = inj_a; B = 32'd7;
                end
            end
        end
        start = 1'b0; MDop = OP_NOP;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_len"}, 64'(cnt), 64'(is_mul_op(op) ? MULT_N : DIV_N));
        exp_hi = expv[63:32];
        exp_lo = expv[31:0];
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
    endtask

    task automatic mt(input string tag, input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; MDop = op; A = a;
        @(negedge clk);
        start = 1'b0; MDop = OP_NOP;
        if (op == OP_MTHI) exp_hi = a;
        else exp_lo = a;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(exp_hi));
        check({tag, "_lo"}, 64'(LO), 64'(exp_lo));
    endtask

    task automatic check_mf(input string tag);
        @(negedge clk);
        MDop = OP_MFHI; #1;
        check({tag, "_mfhi"}, 64'(MDresult), 64'(exp_hi));
        MDop = OP_MFLO; #1;
        check({tag, "_mflo"}, 64'(MDresult), 64'(exp_lo));
        MDop = OP_NOP; #1;
        check({tag, "_mdnop"}, 64'(MDresult), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  ops[$];
        logic [3:0]  op;
        logic [31:0] ra, rb;
        int          cnt;

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        check_mf("rst");

        run_md("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, OP_NOP, 32'd0);
        check("mult_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFA);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, OP_NOP, 32'd0);
        check("multu_hi_const", 64'(HI), 64'd1);
        run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, OP_NOP, 32'd0);
        check("div_lo_const", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        check("div_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        run_md("divu", OP_DIVU, 32'd7, 32'd2, 0, OP_NOP, 32'd0);
        run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, OP_NOP, 32'd0);
        check("div_ovf_lo_const", 64'(LO), 64'h0000_0000_8000_0000);

        mt("mthi", OP_MTHI, 32'h11);
        mt("mtlo", OP_MTLO, 32'h22);
        run_md("div0_inject", OP_DIV, 32'h1234, 32'd0, 3, OP_MULT, 32'd9);
        run_md("relaunch_edge", OP_DIVU, 32'd1000, 32'd7, DIV_N, OP_MTHI, 32'h5555_5555);
        check_mf("relaunch");

        mt("mtlo_beef", OP_MTLO, 32'hDEAD_BEEF);
        check_mf("mf_beef");

`ifndef MDU_MADD_EN
        @(negedge clk);
        start = 1'b1; MDop = OP_MADD; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0; MDop = OP_NOP;
        check("madd_nop_busy", 64'(busy), 64'd0);
        check("madd_nop_lo", 64'(LO), 64'(exp_lo));
`endif

        // Reset mid-operation: no late write-back may follow.
        @(negedge clk);
        start = 1'b1; MDop = OP_DIV; A = 32'd100; B = 32'd7;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0; MDop = OP_NOP;
            if (busy) cnt++;
        end
        check("midrst_pre_busy", 64'(cnt), 64'd4);
        reset_n = 1'b0;
        @(negedge clk);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(HI), 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        reset_n = 1'b1;
        repeat (DIV_N + 2) @(negedge clk);
        check("midrst_late_busy", 64'(busy), 64'd0);
        check("midrst_late_hi", 64'(HI), 64'd0);
        check("midrst_late_lo", 64'(LO), 64'd0);

`ifdef MDU_MADD_EN
        mt("madd_pre_hi", OP_MTHI, 32'd0);
        mt("madd_pre_lo", OP_MTLO, 32'd5);
        run_md("madd", OP_MADD, 32'd2, 32'd3, 0, OP_NOP, 32'd0);
        check("madd_lo_const", 64'(LO), 64'd11);
        run_md("msub", OP_MSUB, 32'd4, 32'd4, 0, OP_NOP, 32'd0);
`endif

        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
`ifdef MDU_MADD_EN
        ops.push_back(OP_MADD);
        ops.push_back(OP_MADDU);
        ops.push_back(OP_MSUB);
        ops.push_back(OP_MSUBU);
`endif
        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, ops.size() - 1)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                3: ra = 32'd0 - 32'($urandom_range(1, 1000));
                default: ;
            endcase
            if (k % 4 == 0) mt("rnd_mt", ($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
            if ($urandom_range(0, 2) == 0)
                run_md("rnd_inj", op, ra, rb,
                       $urandom_range(1, is_mul_op(op) ? MULT_N : DIV_N),
                       4'($urandom_range(1, 12)), $urandom);
            else
                run_md("rnd", op, ra, rb, 0, OP_NOP, 32'd0);
            if (k % 8 == 0) check_mf("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It sits alongside the ALU and takes the same forwarded A/B operands.
- Owns the architectural HI/LO registers. Executes MULT/MULTU/DIV/DIVU with fixed latency, MTHI/MTLO as single-cycle writes, and MFHI/MFLO as combinational reads.
- Drives `busy` to the hazard unit, which stalls any MD instruction in ID while `start` or `busy` is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  synchronous active-low reset
- A  input  32  operand rs (forwarded)
- B  input  32  operand rt (forwarded)
- MDop  input  4  operation select, encodings listed under Behaviour
- start  input  1  one-cycle strobe marking a valid MD instruction in EX
- busy  output  1  a mult/div is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MDresult  output  32  HI when MDop=MFHI, LO when MDop=MFLO, otherwise 0

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low: sampled on the rising clk edge while reset_n=0.
  - Reset values: HI=0, LO=0, busy=0, internal counter=0, pending result regs=0.
- MDop encodings:
  - 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU
  - 0101 MTHI, 0110 MTLO, 0111 MFHI, 1000 MFLO
  - all others NOP
- Mult/div launch:
  - Accepted at edge T0 only when start=1, busy=0 and MDop is a mult/div.
  - At T0: compute the 64-bit result into pending regs, load counter with N (MULT_CYCLES or DIV_CYCLES), set busy=1.
- Mult/div completion:
  - Counter decrements each edge.
  - At edge T0+N: HI/LO take the pending values, busy=0, counter=0.
  - busy is therefore high for exactly N cycles. HI/LO are visible the cycle after busy falls.
- MULT/MULTU: {HI,LO} = signed or unsigned 32x32 product (64-bit, no truncation).
- DIV/DIVU:
  - LO = quotient, truncated toward zero. HI = remainder, sign follows dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0):
  - Op is still accepted and busy runs DIV_CYCLES.
  - HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - With start=1 and busy=0, HI or LO takes A at that edge. No busy.
- MFHI/MFLO:
  - Purely combinational from current HI/LO. No register update.
  - While busy=1, MDresult still shows the old HI/LO; the hazard unit guarantees no such read occurs.
- start=1 while busy=1: ignored completely. No relaunch, no MT write, in-flight op unaffected.
- start=0: MDop is don't-care, no state change.
- reset_n=0 mid-operation: in-flight op aborted, HI/LO cleared, busy=0 at that edge. No late write-back.
- Relaunch timing: a new op with start=1 on the same edge busy falls to 0 is NOT accepted, because busy was still 1 when sampled. First legal relaunch is one cycle later.

Optional Feature:
- Macro: MDU_MADD_EN
- Defined:
  - Adds MDop 1001 MADD, 1010 MADDU, 1011 MSUB, 1100 MSUBU.
  - {HI,LO} = {HI,LO} ± product, signed or unsigned, modulo 2^64.
  - Latency MULT_CYCLES.
  - The accumulate base is the {HI,LO} value sampled at the launch edge T0.
- Undefined: encodings 1001-1100 are NOP; no accumulate adder is synthesised.

Test Plan:
- Reset, MULT launch, timing and product:
  - Stimulus: reset_n=0 two cycles then 1; MULT A=0xFFFFFFFE, B=3, start one cycle.
  - Required: busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU:
  - Stimulus: A=0xFFFFFFFF, B=2.
  - Required: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV, then DIVU, then signed overflow:
  - DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 -> LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and start-while-busy:
  - Stimulus: preset HI=0x11, LO=0x22 via MTHI/MTLO; DIV B=0; pulse MULT start at busy cycle 3.
  - Required: busy runs 10 cycles only (MULT ignored); HI/LO stay 0x11/0x22.
- MT/MF:
  - Stimulus: MTLO A=0xDEADBEEF; next cycle MDop=MFLO.
  - Required: MDresult=0xDEADBEEF, busy never asserted.
- Reset mid-operation, then MADD (only with MDU_MADD_EN):
  - Stimulus: DIV launched, reset_n=0 at busy cycle 4.
  - Required: busy=0 and HI=LO=0 next cycle; no write-back later.
  - Then with HI=0, LO=5, MADD A=2, B=3 -> HI=0, LO=11.
